// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter
//   Shares one barrier gate between the entrance and exit lanes. Arbitrates
//   lane requests round-robin, sequences the password check for entries,
//   times the gate opening and keeps the occupancy count.
// Ports
//   clk, reset_n           system clock (rising edge), async active-low reset
//   entry_req, exit_req    level requests from the lane sensors
//   pass_valid, pass_ok    password verdict pulse and its result
//   pass_start             pulse: checker captures the entered password
//   gate_open              barrier raised
//   grant_entry/grant_exit lane currently owning the gate
//   deny                   pulse: wrong password or verdict timeout
//   occupancy, full, busy  car count, count==CAPACITY, FSM not idle
// Every output is a flop; the values loaded are derived from the next state
// so outputs always line up with the state register.
module parking_gate_arbiter #(
    parameter int CAPACITY    = 8,
    parameter int CNT_W       = 4,
    parameter int OPEN_CYCLES = 16,
    parameter int PW_TIMEOUT  = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             pass_valid,
    input  logic             pass_ok,
    output logic             pass_start,
    output logic             gate_open,
    output logic             grant_entry,
    output logic             grant_exit,
    output logic             deny,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             busy
);
    localparam int TMAX = (OPEN_CYCLES > PW_TIMEOUT) ? OPEN_CYCLES : PW_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_PASS, OPEN_ENTRY, OPEN_EXIT, CLEAR
    } state_t;

    state_t            state, state_nxt;
    logic [TW-1:0]     timer;
    logic              last_exit, last_exit_nxt;   // 1: exit lane served last
    logic [CNT_W-1:0]  occ_nxt;
    logic              deny_nxt, pass_start_nxt;
    logic              entry_ok, exit_ok;

    assign entry_ok = entry_req && !full;
    assign exit_ok  = exit_req && (occupancy != '0);

    always_comb begin
        state_nxt      = state;
        last_exit_nxt  = last_exit;
        occ_nxt        = occupancy;
        deny_nxt       = 1'b0;
        pass_start_nxt = 1'b0;
        case (state)
            IDLE: begin
                // With both lanes eligible, serve the one not served last.
                if (entry_ok && (!exit_ok || last_exit)) begin
                    state_nxt      = WAIT_PASS;
                    last_exit_nxt  = 1'b0;
                    pass_start_nxt = 1'b1;
                end else if (exit_ok) begin
                    state_nxt     = OPEN_EXIT;
                    last_exit_nxt = 1'b1;
                end
            end
            WAIT_PASS: begin
                // A verdict in the same cycle as the car leaving still counts.
                if (pass_valid && pass_ok) begin
                    state_nxt = OPEN_ENTRY;
                end else if (pass_valid || timer == TW'(PW_TIMEOUT - 1)) begin
                    state_nxt = CLEAR;
                    deny_nxt  = 1'b1;
                end else if (!entry_req) begin
                    state_nxt = IDLE;
                end
            end
            OPEN_ENTRY: begin
                if (timer == TW'(OPEN_CYCLES - 1)) begin
                    state_nxt = CLEAR;
                    if (occupancy != CNT_W'(CAPACITY)) occ_nxt = occupancy + CNT_W'(1);
                end
            end
            OPEN_EXIT: begin
                if (timer == TW'(OPEN_CYCLES - 1)) begin
                    state_nxt = CLEAR;
                    if (occupancy != '0) occ_nxt = occupancy - CNT_W'(1);
                end
            end
            CLEAR: begin
                // Hold until the served car has left its sensor.
                if (last_exit ? !exit_req : !entry_req) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            timer       <= '0;
            last_exit   <= 1'b1;
            occupancy   <= '0;
            full        <= 1'b0;
            busy        <= 1'b0;
            gate_open   <= 1'b0;
            grant_entry <= 1'b0;
            grant_exit  <= 1'b0;
            deny        <= 1'b0;
            pass_start  <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_exit <= last_exit_nxt;
            occupancy <= occ_nxt;
            // Timer restarts on every state change and parks at all-ones.
            if (state_nxt != state)  timer <= '0;
            else if (timer != '1)    timer <= timer + TW'(1);
            full        <= (occ_nxt == CNT_W'(CAPACITY));
            busy        <= (state_nxt != IDLE);
            gate_open   <= (state_nxt == OPEN_ENTRY) || (state_nxt == OPEN_EXIT);
            grant_entry <= (state_nxt == WAIT_PASS) || (state_nxt == OPEN_ENTRY);
            grant_exit  <= (state_nxt == OPEN_EXIT);
            deny        <= deny_nxt;
            pass_start  <= pass_start_nxt;
        end
    end
endmodule

// File: tb/tb_parking_gate_arbiter.sv
module tb_parking_gate_arbiter;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       entry_req = 1'b0, exit_req = 1'b0, pass_valid = 1'b0, pass_ok = 1'b0;
    logic       pass_start, gate_open, grant_entry, grant_exit, deny, full, busy;
    logic [3:0] occupancy;
    int         checks = 0, errors = 0;
    int         cnt;
    logic       seen;

    parking_gate_arbiter dut (
        .clk(clk), .reset_n(reset_n), .entry_req(entry_req), .exit_req(exit_req),
        .pass_valid(pass_valid), .pass_ok(pass_ok), .pass_start(pass_start),
        .gate_open(gate_open), .grant_entry(grant_entry), .grant_exit(grant_exit),
        .deny(deny), .occupancy(occupancy), .full(full), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts gate_open high samples starting now (bounded).
    task automatic count_open(output int n);
        n = 0;
        while (gate_open && n < 40) begin n++; step(); end
    endtask

    // Full successful entry from IDLE; verdict two cycles after pass_start.
    task automatic do_entry(input logic [3:0] occ_exp);
        int n;
        entry_req = 1'b1; step();
        chk("entry_pass_start", pass_start, 1'b1);
        step(); step();
        pass_valid = 1'b1; pass_ok = 1'b1; step();
        pass_valid = 1'b0; pass_ok = 1'b0;
        chk("entry_grant", grant_entry, 1'b1);
        count_open(n);
        chk("entry_open_len", n, 16);
        chk("entry_occ", occupancy, occ_exp);
        entry_req = 1'b0; step();
        chk("entry_idle", busy, 1'b0);
    endtask

    task automatic do_exit(input logic [3:0] occ_exp);
        int n;
        exit_req = 1'b1; step();
        chk("exit_grant", grant_exit, 1'b1);
        count_open(n);
        chk("exit_open_len", n, 16);
        chk("exit_occ", occupancy, occ_exp);
        exit_req = 1'b0; step();
        chk("exit_idle", busy, 1'b0);
    endtask

    initial begin
        // 1: reset state, then one correct entry
        step(); step();
        chk("rst_gate", gate_open, 1'b0);
        chk("rst_occ", occupancy, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_deny", deny, 1'b0);
        reset_n = 1'b1; step();
        do_entry(4'd1);

        // 2: wrong password -> deny, hold in CLEAR while entry_req held
        entry_req = 1'b1; step();
        chk("bad_pass_start", pass_start, 1'b1);
        step(); step();
        pass_valid = 1'b1; pass_ok = 1'b0; step();
        pass_valid = 1'b0;
        chk("bad_deny", deny, 1'b1);
        chk("bad_gate", gate_open, 1'b0);
        step();
        chk("bad_deny_pulse", deny, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin seen |= pass_start | gate_open; step(); end
        chk("bad_no_retry", seen, 1'b0);
        chk("bad_hold_clear", busy, 1'b1);
        entry_req = 1'b0; step();
        chk("bad_idle", busy, 1'b0);
        chk("bad_occ", occupancy, 4'd1);

        // 3: no verdict -> deny 32 cycles after entering WAIT_PASS
        entry_req = 1'b1; step();
        cnt = 0;
        while (!deny && cnt < 60) begin step(); cnt++; end
        chk("timeout_cycles", cnt, 32);
        chk("timeout_gate", gate_open, 1'b0);
        entry_req = 1'b0; step();
        chk("timeout_idle", busy, 1'b0);

        // 4: fill to capacity, entry ignored while full, exit frees a slot
        for (int k = 2; k <= 8; k++) do_entry(4'(k));
        chk("full_set", full, 1'b1);
        entry_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin step(); seen |= pass_start | busy; end
        chk("full_ignored", seen, 1'b0);
        exit_req = 1'b1; step();
        chk("full_exit_grant", grant_exit, 1'b1);
        count_open(cnt);
        chk("full_exit_len", cnt, 16);
        chk("full_exit_occ", occupancy, 4'd7);
        chk("full_clear", full, 1'b0);
        exit_req = 1'b0; step();
        step();
        chk("held_entry_served", pass_start, 1'b1);
        entry_req = 1'b0; step();
        chk("entry_abandon", busy, 1'b0);
        chk("abandon_occ", occupancy, 4'd7);
        for (int k = 6; k >= 3; k--) do_exit(4'(k));

        // 5: simultaneous pair after an exit -> entry first, then exit
        entry_req = 1'b1; exit_req = 1'b1; step();
        chk("rr_entry_first", grant_entry, 1'b1);
        chk("rr_entry_ps", pass_start, 1'b1);
        step(); step();
        pass_valid = 1'b1; pass_ok = 1'b1; step();
        pass_valid = 1'b0; pass_ok = 1'b0;
        count_open(cnt);
        chk("rr_entry_occ", occupancy, 4'd4);
        entry_req = 1'b0; step(); step();
        chk("rr_exit_next", grant_exit, 1'b1);
        count_open(cnt);
        chk("rr_final_occ", occupancy, 4'd3);
        exit_req = 1'b0; step();
        // after an entry, the next pair is served exit first
        do_entry(4'd4);
        entry_req = 1'b1; exit_req = 1'b1; step();
        chk("rr_exit_first", grant_exit, 1'b1);
        chk("rr_exit_first_ge", grant_entry, 1'b0);

        // 6: async reset mid OPEN_EXIT
        step(); step(); step();
        chk("pre_rst_gate", gate_open, 1'b1);
        #2 reset_n = 1'b0; #1;
        chk("async_gate", gate_open, 1'b0);
        chk("async_occ", occupancy, 4'd0);
        chk("async_busy", busy, 1'b0);
        step();
        entry_req = 1'b0; reset_n = 1'b1; step();
        step();
        chk("empty_exit_grant", grant_exit, 1'b0);
        chk("empty_exit_busy", busy, 1'b0);
        chk("empty_exit_gate", gate_open, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
